// File: rtl/exp_golomb_encoder_pipe_if.sv
// Symbol-in / codeword-out stream bundle for the exp-Golomb encoder.
// The master side produces symbols and consumes codewords; the slave side is the encoder.
interface exp_golomb_encoder_pipe_if #(
   parameter int VAL_WIDTH = 32,
   parameter int K_WIDTH   = 3,
   parameter int RICE_QMAX = 2
);
   localparam int CW_WIDTH  = VAL_WIDTH + 2;
   localparam int LEN_WIDTH = $clog2(2 * VAL_WIDTH + RICE_QMAX + 4);

   logic                 in_valid;
   logic                 in_ready;
   logic [VAL_WIDTH-1:0] in_val;
   logic [K_WIDTH-1:0]   in_k;
   logic                 in_hybrid;
   logic                 in_sign_en;
   logic                 in_sign;
   logic                 out_valid;
   logic                 out_ready;
   logic [CW_WIDTH-1:0]  out_codeword;
   logic [LEN_WIDTH-1:0] out_length;

   modport master (
      output in_valid, in_val, in_k, in_hybrid, in_sign_en, in_sign, out_ready,
      input  in_ready, out_valid, out_codeword, out_length
   );

   modport slave (
      input  in_valid, in_val, in_k, in_hybrid, in_sign_en, in_sign, out_ready,
      output in_ready, out_valid, out_codeword, out_length
   );
endinterface

// File: rtl/exp_golomb_encoder_pipe.sv
// Three-stage exp-Golomb / hybrid Rice codeword generator with valid/ready
// backpressure and bubble collapsing. Codewords are right-aligned; the length
// tells the packer how many leading zeros are implied.
module exp_golomb_encoder_pipe #(
   parameter int VAL_WIDTH = 32,
   parameter int K_WIDTH   = 3,
   parameter int RICE_QMAX = 2
) (
   input logic                    clk,
   input logic                    reset_n,
   exp_golomb_encoder_pipe_if.slave bus
);
   localparam int CW_WIDTH  = VAL_WIDTH + 2;
   localparam int LEN_WIDTH = $clog2(2 * VAL_WIDTH + RICE_QMAX + 4);
   localparam int SW        = VAL_WIDTH + 1;

   // Stage load enables: a stage loads when it is empty or its successor loads.
   logic ld1, ld2, ld3;
   logic v1_reg, v2_reg, v3_reg;

   assign ld3          = !v3_reg || bus.out_ready;
   assign ld2          = !v2_reg || ld3;
   assign ld1          = !v1_reg || ld2;
   assign bus.in_ready = ld1;

   // ---------------- Stage 1: mode decision and s ----------------
   logic [VAL_WIDTH-1:0] r_c;
   logic                 rice_c;
   logic                 esc_c;
   logic [SW-1:0]        pow_k_c;
   logic [VAL_WIDTH-1:0] esc_off_c;
   logic [VAL_WIDTH-1:0] adj_c;
   logic [SW-1:0]        s_c;
   logic [LEN_WIDTH-1:0] rice_len_c;

   logic                 s1_rice_reg, s1_esc_reg, s1_sign_en_reg, s1_sign_reg;
   logic [SW-1:0]        s1_s_reg;
   logic [LEN_WIDTH-1:0] s1_rice_len_reg;
   logic [K_WIDTH-1:0]   s1_k_reg;

   // Decide Rice vs exp-Golomb, form s (or the Rice codeword) and the Rice length.
   always_comb begin
      r_c       = bus.in_val >> bus.in_k;
      rice_c    = bus.in_hybrid && (r_c <= VAL_WIDTH'(RICE_QMAX));
      esc_c     = bus.in_hybrid && !rice_c;
      pow_k_c   = SW'(1) << bus.in_k;
      // Only consumed on escape, where it cannot exceed in_val.
      esc_off_c = VAL_WIDTH'(RICE_QMAX + 1) << bus.in_k;
      adj_c     = esc_c ? (bus.in_val - esc_off_c) : bus.in_val;
      if (rice_c)
         s_c = pow_k_c | {1'b0, bus.in_val & (pow_k_c[VAL_WIDTH-1:0] - VAL_WIDTH'(1))};
      else
         s_c = {1'b0, adj_c} + pow_k_c;
      // r is at most RICE_QMAX whenever this length is used, so truncation is safe.
      rice_len_c = LEN_WIDTH'(r_c) + LEN_WIDTH'(bus.in_k) + LEN_WIDTH'(1);
   end

   // Stage 1 register: fills from the input whenever it can load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_reg          <= 1'b0;
         s1_rice_reg     <= 1'b0;
         s1_esc_reg      <= 1'b0;
         s1_sign_en_reg  <= 1'b0;
         s1_sign_reg     <= 1'b0;
         s1_s_reg        <= '0;
         s1_rice_len_reg <= '0;
         s1_k_reg        <= '0;
      end else if (ld1) begin
         v1_reg <= bus.in_valid;
         if (bus.in_valid) begin
            s1_rice_reg     <= rice_c;
            s1_esc_reg      <= esc_c;
            s1_sign_en_reg  <= bus.in_sign_en;
            s1_sign_reg     <= bus.in_sign;
            s1_s_reg        <= s_c;
            s1_rice_len_reg <= rice_len_c;
            s1_k_reg        <= bus.in_k;
         end
      end
   end

   // ---------------- Stage 2: leading-one detect ----------------
   logic [LEN_WIDTH-1:0] n_c;

   logic                 s2_rice_reg, s2_esc_reg, s2_sign_en_reg, s2_sign_reg;
   logic [SW-1:0]        s2_s_reg;
   logic [LEN_WIDTH-1:0] s2_rice_len_reg;
   logic [K_WIDTH-1:0]   s2_k_reg;
   logic [LEN_WIDTH-1:0] s2_n_reg;

   // Position of the most significant set bit of s (floor(log2 s)).
   always_comb begin
      n_c = '0;
      for (int i = 0; i < SW; i++) begin
         if (s1_s_reg[i]) n_c = LEN_WIDTH'(i);
      end
   end

   // Stage 2 register: takes stage 1 contents and the detected exponent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2_reg          <= 1'b0;
         s2_rice_reg     <= 1'b0;
         s2_esc_reg      <= 1'b0;
         s2_sign_en_reg  <= 1'b0;
         s2_sign_reg     <= 1'b0;
         s2_s_reg        <= '0;
         s2_rice_len_reg <= '0;
         s2_k_reg        <= '0;
         s2_n_reg        <= '0;
      end else if (ld2) begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            s2_rice_reg     <= s1_rice_reg;
            s2_esc_reg      <= s1_esc_reg;
            s2_sign_en_reg  <= s1_sign_en_reg;
            s2_sign_reg     <= s1_sign_reg;
            s2_s_reg        <= s1_s_reg;
            s2_rice_len_reg <= s1_rice_len_reg;
            s2_k_reg        <= s1_k_reg;
            s2_n_reg        <= n_c;
         end
      end
   end

   // ---------------- Stage 3: length and sign ----------------
   logic [LEN_WIDTH-1:0] eg_len_c;
   logic [LEN_WIDTH-1:0] base_len_c;
   logic [LEN_WIDTH-1:0] len_c;
   logic [CW_WIDTH-1:0]  cw_c;

   logic [CW_WIDTH-1:0]  cw_3_reg;
   logic [LEN_WIDTH-1:0] len_3_reg;

   // Exp-Golomb length 2(n-k)+k+1 = 2n-k+1; escape adds the Rice prefix; sign adds one bit.
   always_comb begin
      eg_len_c = (s2_n_reg << 1) - LEN_WIDTH'(s2_k_reg) + LEN_WIDTH'(1);
      if (s2_rice_reg)
         base_len_c = s2_rice_len_reg;
      else if (s2_esc_reg)
         base_len_c = eg_len_c + LEN_WIDTH'(RICE_QMAX + 1);
      else
         base_len_c = eg_len_c;
      if (s2_sign_en_reg) begin
         cw_c  = {s2_s_reg, s2_sign_reg};
         len_c = base_len_c + LEN_WIDTH'(1);
      end else begin
         cw_c  = {1'b0, s2_s_reg};
         len_c = base_len_c;
      end
   end

   // Output register: holds codeword/length stable while the packer stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v3_reg    <= 1'b0;
         cw_3_reg  <= '0;
         len_3_reg <= '0;
      end else if (ld3) begin
         v3_reg <= v2_reg;
         if (v2_reg) begin
            cw_3_reg  <= cw_c;
            len_3_reg <= len_c;
         end
      end
   end

   assign bus.out_valid    = v3_reg;
   assign bus.out_codeword = cw_3_reg;
   assign bus.out_length   = len_3_reg;
endmodule

// File: tb/tb_exp_golomb_encoder_pipe.sv
// Bench for exp_golomb_encoder_pipe: directed vectors, backpressure, bubble
// collapse, mid-stream reset and a randomized stream against an arithmetic model.
module tb_exp_golomb_encoder_pipe;
   localparam int VW   = 32;
   localparam int KW   = 3;
   localparam int QMAX = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   exp_golomb_encoder_pipe_if #(.VAL_WIDTH(VW), .K_WIDTH(KW), .RICE_QMAX(QMAX)) bus ();

   exp_golomb_encoder_pipe #(.VAL_WIDTH(VW), .K_WIDTH(KW), .RICE_QMAX(QMAX)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      longint unsigned cw;
      int              len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Codeword straight from the coding rules, using 64-bit arithmetic.
   function automatic exp_t model(input longint unsigned val, input int k,
                                  input bit hyb, input bit se, input bit sg);
      exp_t            e;
      longint unsigned r, v, s;
      int              n;
      r = val >> k;
      if (hyb && r <= QMAX) begin
         e.cw  = (64'd1 << k) | (val % (64'd1 << k));
         e.len = int'(r) + 1 + k;
      end else begin
         v = hyb ? val - (longint'(QMAX + 1) << k) : val;
         s = v + (64'd1 << k);
         n = 0;
         while ((s >> (n + 1)) != 0) n++;
         e.cw  = s;
         e.len = 2 * (n - k) + k + 1;
         if (hyb) e.len += QMAX + 1;
      end
      if (se) begin
         e.cw  = e.cw * 2 + longint'(sg);
         e.len = e.len + 1;
      end
      return e;
   endfunction

   // Scoreboard: record accepted symbols, compare every presented codeword.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               check("out_codeword", 64'(bus.out_codeword), exp_q[0].cw);
               check("out_length", 64'(bus.out_length), 64'(exp_q[0].len));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(64'(bus.in_val), int'(bus.in_k), bus.in_hybrid,
                                  bus.in_sign_en, bus.in_sign));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sym(input logic [VW-1:0] val, input int k, input bit hyb,
                          input bit se, input bit sg);
      bus.in_val     = val;
      bus.in_k       = KW'(k);
      bus.in_hybrid  = hyb;
      bus.in_sign_en = se;
      bus.in_sign    = sg;
   endtask

   task automatic rand_sym();
      logic [VW-1:0] val;
      case ($urandom_range(0, 3))
         0:       val = $urandom;
         1:       val = VW'($urandom_range(0, 40));
         2:       val = 32'hFFFF_FFFF - VW'($urandom_range(0, 3));
         default: val = $urandom >> $urandom_range(0, 31);
      endcase
      set_sym(val, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // One symbol with out_ready high: check latency and the expected codeword.
   task automatic send_directed(input string tag, input logic [VW-1:0] val, input int k,
                                input bit hyb, input bit se, input bit sg,
                                input longint unsigned ecw, input int elen);
      int lat;
      set_sym(val, k, hyb, se, sg);
      check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd3);
      check({tag, "_cw"}, 64'(bus.out_codeword), ecw);
      check({tag, "_len"}, 64'(bus.out_length), 64'(elen));
      $display("directed %s val=%0d k=%0d hyb=%0d se=%0d cw=0x%0h len=%0d", tag, val, k,
               hyb, se, bus.out_codeword, bus.out_length);
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && t < 200) begin
         step();
         t++;
      end
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      set_sym('0, 0, 1'b0, 1'b0, 1'b0);

      // Reset state
      step();
      step();
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_out_cw", 64'(bus.out_codeword), 64'd0);
      check("rst_out_len", 64'(bus.out_length), 64'd0);
      reset_n = 1'b1;
      step();
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Directed vectors
      send_directed("eg_k0_v0", 32'd0, 0, 1'b0, 1'b0, 1'b0, 64'd1, 1);
      send_directed("eg_k0_v3", 32'd3, 0, 1'b0, 1'b0, 1'b0, 64'd4, 5);
      send_directed("eg_sign", 32'd5, 2, 1'b0, 1'b1, 1'b1, 64'd19, 6);
      send_directed("rice_k1", 32'd3, 1, 1'b1, 1'b0, 1'b0, 64'd3, 3);
      send_directed("rice_k0", 32'd2, 0, 1'b1, 1'b0, 1'b0, 64'd1, 3);
      send_directed("escape_k0", 32'd5, 0, 1'b1, 1'b0, 1'b0, 64'd3, 6);
      send_directed("eg_v0_k5", 32'd0, 5, 1'b0, 1'b0, 1'b0, 64'd32, 6);
      send_directed("eg_max", 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 64'h1_0000_0000, 65);
      send_directed("eg_max_sign", 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 1'b1, 64'h2_0000_0001, 66);
      wait_drain("directed");

      // Backpressure: six symbols with the packer stalled for five cycles
      bus.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         rand_sym();
         bus.in_valid = 1'b1;
         if (bus.in_ready) acc++;
         step();
      end
      check("bp_accepted", 64'(acc), 64'd3);
      check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      bus.out_ready = 1'b1;
      #1;
      check("bp_in_ready_release", {63'd0, bus.in_ready}, 64'd1);
      for (int c = 0; c < 10 && acc < 6; c++) begin
         if (c != 0) rand_sym();
         if (bus.in_ready) acc++;
         step();
      end
      bus.in_valid = 1'b0;
      check("bp_total_accepted", 64'(acc), 64'd6);
      wait_drain("bp");
      $display("backpressure accepted=%0d outputs_so_far=%0d", acc, n_out);

      // Bubble collapse: S3 stalled, S1/S2 still fill from sparse input
      bus.out_ready = 1'b0;
      rand_sym();
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check("bub_s3_full", {63'd0, bus.out_valid}, 64'd1);
      rand_sym();
      bus.in_valid = 1'b1;
      check("bub_ready_a", {63'd0, bus.in_ready}, 64'd1);
      step();
      bus.in_valid = 1'b0;
      check("bub_ready_gap", {63'd0, bus.in_ready}, 64'd1);
      step();
      rand_sym();
      bus.in_valid = 1'b1;
      check("bub_ready_b", {63'd0, bus.in_ready}, 64'd1);
      step();
      bus.in_valid = 1'b0;
      check("bub_full_ready_low", {63'd0, bus.in_ready}, 64'd0);
      bus.out_ready = 1'b1;
      wait_drain("bubble");

      // Randomized stream with random backpressure
      for (int i = 0; i < 400; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         rand_sym();
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_drain("random");
      $display("random stream done outputs=%0d", n_out);

      // Reset with three symbols in flight
      for (int c = 0; c < 3; c++) begin
         rand_sym();
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("midrst_out_len", 64'(bus.out_length), 64'd0);
      check("midrst_out_cw", 64'(bus.out_codeword), 64'd0);
      exp_q.delete();
      step();
      step();
      reset_n = 1'b1;
      #1;
      check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      step();
      send_directed("post_rst", 32'd0, 0, 1'b0, 1'b0, 1'b0, 64'd1, 1);
      for (int c = 0; c < 5; c++) step();
      check("post_rst_idle", {63'd0, bus.out_valid}, 64'd0);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
